// File: rtl/usb_cmd_frame_parser.sv
// Deframes the host command stream (AA 55 | cmd | lenH | lenL | payload | csum), buffers the payload,
// verifies the checksum and replays good frames to the command handlers over a valid/ready stream.
module usb_cmd_frame_parser #(
    parameter int MAX_LEN        = 1024,
    parameter int TIMEOUT_CYCLES = 60000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  usb_data_in,
    input  logic        usb_data_valid_in,
    output logic        cmd_start,
    output logic [7:0]  cmd_type,
    output logic [15:0] cmd_length,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic        cmd_done,
    output logic        err_checksum,
    output logic        err_length,
    output logic        err_timeout,
    output logic        err_overrun,
    output logic        busy
);

    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_SYNC    = 4'd1;
    localparam logic [3:0] S_CMD     = 4'd2;
    localparam logic [3:0] S_LENH    = 4'd3;
    localparam logic [3:0] S_LENL    = 4'd4;
    localparam logic [3:0] S_PAYLOAD = 4'd5;
    localparam logic [3:0] S_CSUM    = 4'd6;
    localparam logic [3:0] S_EMIT    = 4'd7;
    localparam logic [3:0] S_DONE    = 4'd8;

    logic [3:0]    state;
    logic [7:0]    sum;
    logic [7:0]    cmd_q;
    logic [15:0]   len_q;
    logic [15:0]   ptr;
    logic [TW-1:0] timer;
    logic [7:0]    mem [MAX_LEN];
    logic          in_frame;
    logic [15:0]   len_now;

    // Frame reception window in which the inter-byte timer is armed.
    assign in_frame = (state != S_IDLE) && (state != S_EMIT) && (state != S_DONE);
    assign len_now  = {len_q[15:8], usb_data_in};
    assign busy     = (state != S_IDLE);
    assign cmd_done = (state == S_DONE);

    // NOTE: the payload buffer has no reset; its contents are only read after being written by the current frame.
    always_ff @(posedge clk) begin
        if (state == S_PAYLOAD && usb_data_valid_in) begin
            mem[ptr[AW-1:0]] <= usb_data_in;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every branch sees the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            sum          <= '0;
            cmd_q        <= '0;
            len_q        <= '0;
            ptr          <= '0;
            timer        <= '0;
            cmd_start    <= 1'b0;
            cmd_type     <= '0;
            cmd_length   <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            cmd_start    <= 1'b0;
            err_checksum <= 1'b0;
            err_length   <= 1'b0;
            err_timeout  <= 1'b0;
            err_overrun  <= usb_data_valid_in && (state == S_EMIT || state == S_DONE);

            case (state)
                S_IDLE: begin
                    if (usb_data_valid_in && usb_data_in == 8'hAA) state <= S_SYNC;
                end
                S_SYNC: begin
                    if (usb_data_valid_in) begin
                        if (usb_data_in == 8'h55)      state <= S_CMD;
                        else if (usb_data_in != 8'hAA) state <= S_IDLE;
                    end
                end
                S_CMD: begin
                    if (usb_data_valid_in) begin
                        cmd_q <= usb_data_in;
                        sum   <= usb_data_in;
                        state <= S_LENH;
                    end
                end
                S_LENH: begin
                    if (usb_data_valid_in) begin
                        len_q[15:8] <= usb_data_in;
                        sum         <= sum + usb_data_in;
                        state       <= S_LENL;
                    end
                end
                S_LENL: begin
                    if (usb_data_valid_in) begin
                        len_q[7:0] <= usb_data_in;
                        sum        <= sum + usb_data_in;
                        ptr        <= '0;
                        if (len_now > 16'(MAX_LEN)) begin
                            err_length <= 1'b1;
                            state      <= S_IDLE;
                        end else if (len_now == 16'd0) begin
                            state <= S_CSUM;
                        end else begin
                            state <= S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (usb_data_valid_in) begin
                        sum <= sum + usb_data_in;
                        ptr <= ptr + 16'd1;
                        if (ptr == len_q - 16'd1) state <= S_CSUM;
                    end
                end
                S_CSUM: begin
                    if (usb_data_valid_in) begin
                        if (usb_data_in == sum) begin
                            cmd_start  <= 1'b1;
                            cmd_type   <= cmd_q;
                            cmd_length <= len_q;
                            ptr        <= '0;
                            state      <= S_EMIT;
                        end else begin
                            err_checksum <= 1'b1;
                            state        <= S_IDLE;
                        end
                    end
                end
                S_EMIT: begin
                    // Refill the output register whenever it is empty or being consumed this cycle.
                    if (!data_valid || data_ready) begin
                        if (ptr == len_q) begin
                            data_valid <= 1'b0;
                            state      <= S_DONE;
                        end else begin
                            data_out   <= mem[ptr[AW-1:0]];
                            data_valid <= 1'b1;
                            ptr        <= ptr + 16'd1;
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            // A byte arriving in the expiry cycle is consumed above and keeps the frame alive.
            if (in_frame && !usb_data_valid_in) begin
                if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_timeout <= 1'b1;
                    state       <= S_IDLE;
                    timer       <= '0;
                end else begin
                    timer <= timer + 1'b1;
                end
            end else begin
                timer <= '0;
            end
        end
    end

endmodule

// File: tb/tb_usb_cmd_frame_parser.sv
// Directed bench for usb_cmd_frame_parser: a table of whole frames plus hand-written
// sequences for latency, timeout, reset and overrun corner cases.
module tb_usb_cmd_frame_parser;

    localparam int TO = 200;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  usb_data_in;
    logic        usb_data_valid_in;
    logic        cmd_start;
    logic [7:0]  cmd_type;
    logic [15:0] cmd_length;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        data_ready;
    logic        cmd_done;
    logic        err_checksum;
    logic        err_length;
    logic        err_timeout;
    logic        err_overrun;
    logic        busy;

    always #5 clk = ~clk;

    usb_cmd_frame_parser #(.MAX_LEN(1024), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n),
        .usb_data_in(usb_data_in), .usb_data_valid_in(usb_data_valid_in),
        .cmd_start(cmd_start), .cmd_type(cmd_type), .cmd_length(cmd_length),
        .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
        .cmd_done(cmd_done), .err_checksum(err_checksum), .err_length(err_length),
        .err_timeout(err_timeout), .err_overrun(err_overrun), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Event monitor, sampled on the falling edge.
    int n_start = 0, n_done = 0, n_cs = 0, n_len = 0, n_to = 0, n_ovr = 0;
    logic [7:0] rx_q[$];
    bit         prev_stall = 0;
    logic [7:0] prev_data;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid_held", data_valid, 1);
                check("stall_data_held", data_out, prev_data);
            end
            if (cmd_start)    n_start++;
            if (cmd_done)     n_done++;
            if (err_checksum) n_cs++;
            if (err_length)   n_len++;
            if (err_timeout)  n_to++;
            if (err_overrun)  n_ovr++;
            if (data_valid && data_ready) rx_q.push_back(data_out);
            prev_stall = data_valid && !data_ready;
            prev_data  = data_out;
        end
    end

    // data_ready pattern: 0 = always ready, 1 = toggle every cycle, 2 = held low.
    int ready_mode = 0;
    initial begin
        data_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       data_ready = 1'b1;
                1:       data_ready = ~data_ready;
                default: data_ready = 1'b0;
            endcase
        end
    end

    typedef struct {
        string        name;
        logic [127:0] frame;     // first byte in the top bits
        int           nbytes;
        int           rmode;
        int           exp_start;
        logic [7:0]   exp_type;
        logic [15:0]  exp_len;
        logic [63:0]  exp_pay;   // first byte in the top bits
        int           exp_npay;
        int           exp_cs;
        int           exp_lerr;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [127:0] fr, input int n, input int rm,
                                input int st, input logic [7:0] ty, input logic [15:0] ln,
                                input logic [63:0] pay, input int np, input int cs, input int le);
        vec_t v;
        v.name = name; v.nbytes = n; v.rmode = rm; v.exp_start = st; v.exp_type = ty;
        v.exp_len = ln; v.exp_npay = np; v.exp_cs = cs; v.exp_lerr = le;
        v.frame   = fr << (8 * (16 - n));
        v.exp_pay = pay << (8 * (8 - np));
        return v;
    endfunction

    // Issued from posedge+1; consecutive calls stream one byte per cycle.
    task automatic send_byte(input logic [7:0] b);
        usb_data_in       = b;
        usb_data_valid_in = 1'b1;
        @(posedge clk);
        #1;
        usb_data_valid_in = 1'b0;
    endtask

    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k = 0;
        @(negedge clk);
        while (busy && k < 300) begin
            @(negedge clk);
            k++;
        end
        check({name, "/idle_reached"}, busy, 0);
        repeat (2) @(negedge clk);
        #1;
        align();
    endtask

    task automatic apply_reset(input string name);
        rst_n = 1'b0;
        #1;
        check({name, "/busy"}, busy, 0);
        check({name, "/data_valid"}, data_valid, 0);
        check({name, "/data_out"}, data_out, 0);
        check({name, "/cmd_type"}, cmd_type, 0);
        check({name, "/cmd_length"}, cmd_length, 0);
        check({name, "/cmd_start"}, cmd_start, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        align();
    endtask

    task automatic run_vec(input vec_t v);
        int b_start = n_start, b_done = n_done, b_cs = n_cs, b_len = n_len, b_to = n_to, b_ovr = n_ovr;
        rx_q.delete();
        ready_mode = v.rmode;
        for (int i = 0; i < v.nbytes; i++) send_byte(v.frame[127 - 8*i -: 8]);
        wait_idle(v.name);
        ready_mode = 0;
        check($sformatf("%s/cmd_start", v.name), n_start - b_start, v.exp_start);
        check($sformatf("%s/cmd_done", v.name), n_done - b_done, v.exp_start);
        check($sformatf("%s/err_checksum", v.name), n_cs - b_cs, v.exp_cs);
        check($sformatf("%s/err_length", v.name), n_len - b_len, v.exp_lerr);
        check($sformatf("%s/err_timeout", v.name), n_to - b_to, 0);
        check($sformatf("%s/err_overrun", v.name), n_ovr - b_ovr, 0);
        check($sformatf("%s/payload_count", v.name), rx_q.size(), v.exp_npay);
        if (v.exp_start != 0) begin
            check($sformatf("%s/cmd_type", v.name), cmd_type, v.exp_type);
            check($sformatf("%s/cmd_length", v.name), cmd_length, v.exp_len);
        end
        for (int i = 0; i < v.exp_npay && i < rx_q.size(); i++)
            check($sformatf("%s/byte%0d", v.name, i), rx_q[i], v.exp_pay[63 - 8*i -: 8]);
    endtask

    vec_t vecs[9];

    initial begin
        int b0, b1, b2;

        // 05+00+06+00+3C+DE+AD+BE+EF mod 256 = 7F
        vecs[0] = mk("i2c_cfg", 128'({8'hAA,8'h55,8'h04,8'h00,8'h01,8'h50,8'h55}), 7, 0,
                     1, 8'h04, 16'd1, 64'h50, 1, 0, 0);
        vecs[1] = mk("write_toggle", 128'({8'hAA,8'h55,8'h05,8'h00,8'h06,8'h00,8'h3C,8'hDE,8'hAD,8'hBE,8'hEF,8'h7F}), 12, 1,
                     1, 8'h05, 16'd6, 64'h003CDEADBEEF, 6, 0, 0);
        vecs[2] = mk("bad_csum", 128'({8'hAA,8'h55,8'h05,8'h00,8'h06,8'h00,8'h3C,8'hDE,8'hAD,8'hBE,8'hEF,8'h97}), 12, 0,
                     0, 8'h00, 16'd0, 64'h0, 0, 1, 0);
        vecs[3] = mk("after_bad", 128'({8'hAA,8'h55,8'h04,8'h00,8'h01,8'h50,8'h55}), 7, 0,
                     1, 8'h04, 16'd1, 64'h50, 1, 0, 0);
        vecs[4] = mk("len_1025", 128'({8'hAA,8'h55,8'h09,8'h04,8'h01}), 5, 0,
                     0, 8'h00, 16'd0, 64'h0, 0, 0, 1);
        vecs[5] = mk("zero_len", 128'({8'hAA,8'h55,8'h07,8'h00,8'h00,8'h07}), 6, 0,
                     1, 8'h07, 16'd0, 64'h0, 0, 0, 0);
        vecs[6] = mk("resync_aa", 128'({8'h12,8'hAA,8'hAA,8'h55,8'h04,8'h00,8'h01,8'h50,8'h55}), 9, 0,
                     1, 8'h04, 16'd1, 64'h50, 1, 0, 0);
        vecs[7] = mk("aa_as_data", 128'({8'hAA,8'h55,8'h04,8'h00,8'h01,8'hAA,8'hAF}), 7, 0,
                     1, 8'h04, 16'd1, 64'hAA, 1, 0, 0);
        vecs[8] = mk("broken_sync", 128'({8'hAA,8'h12,8'h55,8'h04,8'h00,8'h01,8'h50,8'h55}), 8, 0,
                     0, 8'h00, 16'd0, 64'h0, 0, 0, 0);

        rst_n = 1'b0;
        usb_data_in = 8'h00;
        usb_data_valid_in = 1'b0;
        repeat (3) @(negedge clk);
        check("reset/busy", busy, 0);
        check("reset/cmd_type", cmd_type, 0);
        check("reset/cmd_length", cmd_length, 0);
        check("reset/data_valid", data_valid, 0);
        check("reset/errors", {err_checksum, err_length, err_timeout, err_overrun, cmd_start, cmd_done}, 0);
        align();
        rst_n = 1'b1;
        align();

        foreach (vecs[i]) run_vec(vecs[i]);

        // cmd_start one cycle after the checksum strobe; data no earlier than the cycle after.
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h04); send_byte(8'h00);
        send_byte(8'h01); send_byte(8'h50); send_byte(8'h55);
        @(negedge clk);
        check("lat/cmd_start", cmd_start, 1);
        check("lat/cmd_type", cmd_type, 8'h04);
        check("lat/cmd_length", cmd_length, 16'd1);
        check("lat/no_early_valid", data_valid, 0);
        @(negedge clk);
        check("lat/start_pulse", cmd_start, 0);
        check("lat/data_valid", data_valid, 1);
        check("lat/data_out", data_out, 8'h50);
        @(negedge clk);
        check("lat/data_drop", data_valid, 0);
        check("lat/cmd_done", cmd_done, 1);
        @(negedge clk);
        check("lat/done_pulse", cmd_done, 0);
        check("lat/busy", busy, 0);
        align();

        // Zero-length frame: cmd_done immediately follows cmd_start.
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h07); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h07);
        @(negedge clk);
        check("zl/cmd_start", cmd_start, 1);
        check("zl/cmd_done_early", cmd_done, 0);
        @(negedge clk);
        check("zl/cmd_done", cmd_done, 1);
        check("zl/data_valid", data_valid, 0);
        align();

        // Inter-byte timeout after AA 55 06 00.
        b0 = n_to;
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h06); send_byte(8'h00);
        repeat (TO) @(negedge clk);
        check("to/busy_at_limit", busy, 1);
        check("to/no_early_timeout", err_timeout, 0);
        @(negedge clk);
        check("to/err_timeout", err_timeout, 1);
        check("to/busy", busy, 0);
        #1;
        check("to/count", n_to - b0, 1);
        align();

        // A byte in the expiry cycle keeps the frame alive.
        b0 = n_to; b1 = n_start;
        rx_q.delete();
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h06); send_byte(8'h00);
        repeat (TO - 1) @(posedge clk);
        #1;
        send_byte(8'h01);
        check("to_save/busy", busy, 1);
        send_byte(8'h33); send_byte(8'h3A);
        wait_idle("to_save");
        check("to_save/no_timeout", n_to - b0, 0);
        check("to_save/cmd_start", n_start - b1, 1);
        check("to_save/cmd_type", cmd_type, 8'h06);
        check("to_save/payload", (rx_q.size() == 1) ? rx_q[0] : 8'hXX, 8'h33);

        // Reset mid-payload, then a fresh frame.
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h06); send_byte(8'h00); send_byte(8'h3C);
        apply_reset("rst_payload");
        run_vec(vecs[0]);

        // Reset while a payload byte is stalled in EMIT.
        ready_mode = 2;
        for (int i = 0; i < vecs[1].nbytes; i++) send_byte(vecs[1].frame[127 - 8*i -: 8]);
        repeat (3) @(negedge clk);
        check("rst_emit/data_valid", data_valid, 1);
        check("rst_emit/data_out", data_out, 8'h00);
        check("rst_emit/cmd_length", cmd_length, 16'd6);
        align();
        apply_reset("rst_emit");
        ready_mode = 0;
        run_vec(vecs[5]);

        // Bytes arriving during EMIT are dropped, one err_overrun each, never parsed.
        b0 = n_ovr; b1 = n_start; b2 = n_done;
        rx_q.delete();
        ready_mode = 2;
        for (int i = 0; i < vecs[0].nbytes; i++) send_byte(vecs[0].frame[127 - 8*i -: 8]);
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h04);
        ready_mode = 0;
        wait_idle("overrun");
        check("overrun/count", n_ovr - b0, 3);
        check("overrun/cmd_start", n_start - b1, 1);
        check("overrun/cmd_done", n_done - b2, 1);
        check("overrun/payload", (rx_q.size() == 1) ? rx_q[0] : 8'hXX, 8'h50);
        run_vec(vecs[7]);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
